// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory wait/timeout.
// Optional statistics counters are enabled by defining HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_i,
    input  logic [4:0]  IFID_Rs1_i,
    input  logic [4:0]  IFID_Rs2_i,
    input  logic        Branch_Taken_i,
    input  logic        Mem_Req_i,
    input  logic        Mem_Ack_i,
    output logic        PC_Write_o,
    output logic        IFID_Write_o,
    output logic        IDEX_Write_o,
    output logic        IDEX_Bubble_o,
    output logic        IFID_Flush_o,
    output logic        EXMEM_Hold_o,
    output logic        MEMWB_Bubble_o,
    output logic [1:0]  State_o,
    output logic        Mem_Timeout_o,
    output logic [31:0] Stall_Cnt_o,
    output logic [31:0] Flush_Cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10,
        ST_BAD      = 2'b11
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;
    logic       freeze;

    assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                      ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Mem_Req_i && !Mem_Ack_i) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (Mem_Ack_i) begin
                    state_d = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) state_d = ST_HALT;
                    else                         wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                // HALT is sticky; the unused encoding falls into it as well
                freeze  = 1'b1;
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        PC_Write_o     = 1'b1;
        IFID_Write_o   = 1'b1;
        IDEX_Write_o   = 1'b1;
        IDEX_Bubble_o  = 1'b0;
        IFID_Flush_o   = 1'b0;
        EXMEM_Hold_o   = 1'b0;
        MEMWB_Bubble_o = 1'b0;
        State_o        = state_q;
        Mem_Timeout_o  = (state_q == ST_HALT);
        if (!rst_i) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Write_o   = 1'b0;
            IDEX_Bubble_o  = 1'b1;
            IFID_Flush_o   = 1'b1;
            MEMWB_Bubble_o = 1'b1;
            State_o        = ST_RUN;
            Mem_Timeout_o  = 1'b0;
        end else if (freeze) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Write_o   = 1'b0;
            EXMEM_Hold_o   = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end else if (load_use) begin
            // a stall beats a taken branch; the branch resolves again next cycle
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Branch_Taken_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_Write_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        if (IFID_Flush_o && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt_o = stall_cnt_q;
    assign Flush_Cnt_o = flush_cnt_q;
`else
    assign Stall_Cnt_o = 32'd0;
    assign Flush_Cnt_o = 32'd0;
`endif

endmodule
